// File: rtl/raycast_scheduler_pkg.sv
// Shared types for the raycast scheduler: float16 vector types, the shape
// memory record, the scheduler state encoding and a float16 NaN test.
package proctypes;

  typedef logic [15:0] float16;

  typedef struct packed {
    float16 x;
    float16 y;
    float16 z;
  } vec3;

  typedef struct packed {
    float16 w;
    float16 x;
    float16 y;
    float16 z;
  } quaternion;

  typedef enum logic [1:0] {
    SHAPE_SPHERE   = 2'd0,
    SHAPE_BOX      = 2'd1,
    SHAPE_CYLINDER = 2'd2,
    SHAPE_PLANE    = 2'd3
  } ShapeType;

  // One shape memory word. The kind field is called shape_type because
  // "type" is a reserved word.
  typedef struct packed {
    ShapeType  shape_type;
    vec3       trans_inv;
    quaternion rot;
    vec3       scale_inv;
  } shape_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } sched_state_t;

  // All-ones exponent with a non-zero mantissa is NaN.
  function automatic logic float16_is_nan(input float16 f);
    return (f[14:10] == 5'h1f) && (f[9:0] != 10'd0);
  endfunction

endpackage

// File: rtl/raycast_scheduler_if.sv
// Ray request and per-ray result handshakes of the raycast scheduler.
// Valid/ready: a transfer happens on a rising clock edge where both valid
// and ready are 1; a source holds valid and its payload stable until then.
// Optional macro RAYCAST_SCHED_ANY_HIT_EN adds the ray_any_hit request bit.
interface raycast_scheduler_if #(
  parameter int MAX_SHAPES = 64
) ();
  import proctypes::*;

  localparam int IDX_W = $clog2(MAX_SHAPES);
  localparam int CNT_W = $clog2(MAX_SHAPES + 1);

  logic             ray_valid;
  logic             ray_ready;
  logic [CNT_W-1:0] num_shapes;
  vec3              ray_src;
  vec3              ray_dir;
`ifdef RAYCAST_SCHED_ANY_HIT_EN
  logic             ray_any_hit;
`endif

  logic             res_valid;
  logic             res_ready;
  logic             res_hit;
  logic [IDX_W-1:0] res_shape_idx;
  float16           res_sq_distance;
  vec3              res_intersection;

  // Ray generator / shading side.
  modport master (
`ifdef RAYCAST_SCHED_ANY_HIT_EN
    output ray_any_hit,
`endif
    output ray_valid, num_shapes, ray_src, ray_dir, res_ready,
    input  ray_ready, res_valid, res_hit, res_shape_idx, res_sq_distance,
    input  res_intersection
  );

  // Scheduler side.
  modport slave (
`ifdef RAYCAST_SCHED_ANY_HIT_EN
    input  ray_any_hit,
`endif
    input  ray_valid, num_shapes, ray_src, ray_dir, res_ready,
    output ray_ready, res_valid, res_hit, res_shape_idx, res_sq_distance,
    output res_intersection
  );

endinterface

// File: rtl/raycast_scheduler_nearest_hit_tracker.sv
// Keeps the best hit seen for the current ray. A result is a candidate when
// it hits with a non-NaN distance; the stored best is replaced on a strictly
// smaller 15-bit distance, so ties keep the lower index. In any-hit mode the
// first candidate is kept and later ones are ignored.
module nearest_hit_tracker
  import proctypes::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  input  logic             any_hit,
  input  logic             hit,
  input  float16           sq_distance,
  input  vec3              intersection,
  input  logic [IDX_W-1:0] idx,
  output logic             first_hit,
  output logic             best_hit,
  output logic [IDX_W-1:0] best_idx,
  output float16           best_sq,
  output vec3              best_isect
);

  logic cand;
  logic take;

  assign cand      = en && hit && !float16_is_nan(sq_distance);
  assign first_hit = cand && !best_hit;
  assign take      = first_hit ||
                     (cand && !any_hit && (sq_distance[14:0] < best_sq[14:0]));

  // Best-hit register: cleared at ray accept, loaded on a winning candidate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      best_hit   <= 1'b0;
      best_idx   <= '0;
      best_sq    <= '0;
      best_isect <= '0;
    end else if (start) begin
      best_hit   <= 1'b0;
      best_idx   <= '0;
      best_sq    <= '0;
      best_isect <= '0;
    end else if (take) begin
      best_hit   <= 1'b1;
      best_idx   <= idx;
      best_sq    <= sq_distance;
      best_isect <= intersection;
    end
  end

endmodule

// File: rtl/raycast_scheduler.sv
// Sequences the raycaster for one ray at a time: streams the active shapes
// from the shape memory (1-cycle read latency) one per cycle, counts the
// in-order results, keeps the nearest valid hit and returns one result.
// Optional macro RAYCAST_SCHED_ANY_HIT_EN enables any-hit early termination.
module raycast_scheduler
  import proctypes::*;
#(
  parameter  int MAX_SHAPES = 64,
  localparam int IDX_W      = $clog2(MAX_SHAPES),
  localparam int CNT_W      = $clog2(MAX_SHAPES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  raycast_scheduler_if.slave    bus,
  output logic [IDX_W-1:0]      shape_addr,
  input  shape_t                shape_data,
  output logic                  rc_valid_in,
  output vec3                   rc_src,
  output vec3                   rc_dir,
  output ShapeType              rc_shape_type,
  output vec3                   rc_trans_inv,
  output quaternion             rc_rot,
  output vec3                   rc_scale_inv,
  input  logic                  rc_valid_out,
  input  logic                  rc_hit,
  input  float16                rc_sq_distance,
  input  vec3                   rc_intersection,
  output sched_state_t          dbg_state
);

  sched_state_t     state, state_nx;
  logic [CNT_W-1:0] issue_cnt, ret_cnt, ret_nx, num_q, target_q;
  vec3              src_q, dir_q;
  logic             live_q, rc_vld_q, any_q;
  logic             accept, in_flight, res_en, first_hit, stop;

  assign accept    = bus.ray_valid && bus.ray_ready;
  assign in_flight = (state == S_ISSUE) || (state == S_DRAIN);
  assign res_en    = rc_valid_out && in_flight;
  assign ret_nx    = ret_cnt + CNT_W'(res_en);
  assign stop      = any_q && first_hit && (state == S_ISSUE);

`ifdef RAYCAST_SCHED_ANY_HIT_EN
  // Any-hit request bit, captured with the ray.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        any_q <= 1'b0;
    else if (accept) any_q <= bus.ray_any_hit;
  end
`else
  assign any_q = 1'b0;
`endif

  // Next-state logic. On an any-hit stop the target shrinks to what was
  // actually issued, so DONE still waits for every in-flight result.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (accept) state_nx = (bus.num_shapes == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: begin
        if (stop)                                   state_nx = (ret_nx == issue_cnt) ? S_DONE : S_DRAIN;
        else if (issue_cnt == num_q - CNT_W'(1))    state_nx = S_DRAIN;
      end
      S_DRAIN: if (ret_nx == target_q) state_nx = S_DONE;
      S_DONE:  if (bus.res_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State, ray latch, issue/return counters and the delayed issue valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      live_q    <= 1'b0;
      rc_vld_q  <= 1'b0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      num_q     <= '0;
      target_q  <= '0;
      src_q     <= '0;
      dir_q     <= '0;
    end else begin
      state    <= state_nx;
      live_q   <= 1'b1;
      rc_vld_q <= (state == S_ISSUE) && !stop;
      if (accept) begin
        src_q     <= bus.ray_src;
        dir_q     <= bus.ray_dir;
        num_q     <= bus.num_shapes;
        target_q  <= bus.num_shapes;
        issue_cnt <= '0;
        ret_cnt   <= '0;
      end else begin
        if (state == S_ISSUE) begin
          if (stop) target_q  <= issue_cnt;
          else      issue_cnt <= issue_cnt + CNT_W'(1);
        end
        if (res_en) ret_cnt <= ret_nx;
      end
    end
  end

  nearest_hit_tracker #(.IDX_W(IDX_W)) u_tracker (
    .clk          (clk),
    .rst          (rst),
    .start        (accept),
    .en           (res_en),
    .any_hit      (any_q),
    .hit          (rc_hit),
    .sq_distance  (rc_sq_distance),
    .intersection (rc_intersection),
    .idx          (ret_cnt[IDX_W-1:0]),
    .first_hit    (first_hit),
    .best_hit     (bus.res_hit),
    .best_idx     (bus.res_shape_idx),
    .best_sq      (bus.res_sq_distance),
    .best_isect   (bus.res_intersection)
  );

  assign bus.ray_ready = live_q && (state == S_IDLE);
  assign bus.res_valid = (state == S_DONE);
  assign dbg_state     = state;

  assign shape_addr    = issue_cnt[IDX_W-1:0];
  assign rc_valid_in   = rc_vld_q;
  assign rc_src        = src_q;
  assign rc_dir        = dir_q;
  assign rc_shape_type = rc_vld_q ? shape_data.shape_type : SHAPE_SPHERE;
  assign rc_trans_inv  = rc_vld_q ? shape_data.trans_inv  : '0;
  assign rc_rot        = rc_vld_q ? shape_data.rot        : '0;
  assign rc_scale_inv  = rc_vld_q ? shape_data.scale_inv  : '0;

endmodule

// File: tb/tb_raycast_scheduler.sv
// Bench for raycast_scheduler: shape memory and a fixed-latency raycaster
// model around the DUT, a per-ray reference result from the shape tables,
// directed cases plus randomized rays.
module tb_raycast_scheduler;
  import proctypes::*;

  localparam int MAX_SHAPES = 64;
  localparam int IDX_W      = 6;
  localparam int CNT_W      = 7;
  localparam int LAT        = 3;
  localparam int RES_W      = 1 + IDX_W + 16 + 48;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  raycast_scheduler_if #(.MAX_SHAPES(MAX_SHAPES)) bus ();

  logic [IDX_W-1:0] shape_addr;
  shape_t           shape_data;
  logic             rc_valid_in, rc_valid_out, rc_hit;
  vec3              rc_src, rc_dir, rc_trans_inv, rc_scale_inv, rc_intersection;
  ShapeType         rc_shape_type;
  quaternion        rc_rot;
  float16           rc_sq_distance;
  sched_state_t     dbg_state;

  raycast_scheduler #(.MAX_SHAPES(MAX_SHAPES)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .shape_addr(shape_addr), .shape_data(shape_data),
    .rc_valid_in(rc_valid_in), .rc_src(rc_src), .rc_dir(rc_dir),
    .rc_shape_type(rc_shape_type), .rc_trans_inv(rc_trans_inv),
    .rc_rot(rc_rot), .rc_scale_inv(rc_scale_inv),
    .rc_valid_out(rc_valid_out), .rc_hit(rc_hit),
    .rc_sq_distance(rc_sq_distance), .rc_intersection(rc_intersection),
    .dbg_state(dbg_state)
  );

  // ---------------- environment models ----------------
  shape_t     mem     [MAX_SHAPES];
  logic       hit_tab [MAX_SHAPES];
  float16     sq_tab  [MAX_SHAPES];
  logic       pv   [LAT] = '{default: 1'b0};
  logic [IDX_W-1:0] pidx [LAT] = '{default: '0};

  // Synchronous-read shape memory.
  always @(posedge clk) shape_data <= mem[shape_addr];

  // Raycaster: shape index travels in trans_inv.x, result comes LAT cycles later.
  always @(posedge clk) begin
    pv[0]   <= rc_valid_in;
    pidx[0] <= rc_trans_inv.x[IDX_W-1:0];
    for (int i = 1; i < LAT; i++) begin
      pv[i]   <= pv[i-1];
      pidx[i] <= pidx[i-1];
    end
  end
  assign rc_valid_out    = pv[LAT-1];
  assign rc_hit          = hit_tab[pidx[LAT-1]];
  assign rc_sq_distance  = sq_tab[pidx[LAT-1]];
  assign rc_intersection = {sq_tab[pidx[LAT-1]], sq_tab[pidx[LAT-1]] ^ 16'h5a5a, 16'(pidx[LAT-1])};

  // ---------------- scoreboard ----------------
  logic [RES_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_nan16(input logic [15:0] f);
    return (f[14:10] == 5'h1f) && (f[9:0] != 10'd0);
  endfunction

  function automatic int first_cand(input int n);
    for (int i = 0; i < n; i++)
      if (hit_tab[i] && !is_nan16(sq_tab[i])) return i;
    return -1;
  endfunction

  // Expected per-ray result: nearest candidate (first on ties) or first candidate.
  function automatic logic [RES_W-1:0] model(input int n, input bit any);
    int best = -1;
    if (any) best = first_cand(n);
    else
      for (int i = 0; i < n; i++)
        if (hit_tab[i] && !is_nan16(sq_tab[i]))
          if (best < 0 || sq_tab[i][14:0] < sq_tab[best][14:0]) best = i;
    if (best < 0) return '0;
    return {1'b1, IDX_W'(best), sq_tab[best], sq_tab[best], sq_tab[best] ^ 16'h5a5a, 16'(best)};
  endfunction

  function automatic logic [RES_W-1:0] res_now();
    return {bus.res_hit, bus.res_shape_idx, bus.res_sq_distance, bus.res_intersection};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic fill_mem();
    for (int i = 0; i < MAX_SHAPES; i++) begin
      mem[i].shape_type = ShapeType'($urandom_range(0, 3));
      mem[i].trans_inv  = {16'(i), 16'($urandom), 16'($urandom)};
      mem[i].rot        = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      mem[i].scale_inv  = {16'($urandom), 16'($urandom), 16'($urandom)};
    end
  endtask

  task automatic set_shape(input int i, input logic h, input logic [15:0] sq);
    hit_tab[i] = h;
    sq_tab[i]  = sq;
  endtask

  task automatic random_tables(input int n);
    logic [15:0] sq;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 7))
        0: sq = 16'h3C00;
        1: sq = 16'hBC00;
        2: sq = 16'h4000;
        3: sq = 16'h4400;
        4: sq = 16'h7E00;
        5: sq = 16'h7C00;
        default: sq = {1'($urandom), 5'($urandom_range(0, 30)), 10'($urandom)};
      endcase
      set_shape(i, 1'($urandom_range(0, 1)), sq);
    end
  endtask

  task automatic run_ray(input int n, input bit any, input int hold, input string tag);
    vec3 src, dir;
    int k, fk, exp_in, n_in, first_in, last_in, last_out, res_k;
    logic [RES_W-1:0] got;
    src = {16'($urandom), 16'($urandom), 16'($urandom)};
    dir = {16'($urandom), 16'($urandom), 16'($urandom)};
    fill_mem();
    exp_q.push_back(model(n, any));
    fk = first_cand(n);
    exp_in = (any && fk >= 0 && fk + LAT + 1 < n) ? fk + LAT + 1 : n;

    @(negedge clk);
    bus.num_shapes = CNT_W'(n);
    bus.ray_src    = src;
    bus.ray_dir    = dir;
`ifdef RAYCAST_SCHED_ANY_HIT_EN
    bus.ray_any_hit = any;
`endif
    bus.ray_valid  = 1'b1;
    k = 0;
    while (!bus.ray_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_accept"}, bus.ray_ready, 1);
    @(negedge clk);
    bus.ray_valid = 1'b0;
    check_eq({tag, "_busy"}, bus.ray_ready, 0);

    n_in = 0; first_in = -1; last_in = -1; last_out = -1; res_k = -1;
    for (int c = 1; c <= 400; c++) begin
      if (bus.res_valid) begin
        res_k = c;
        break;
      end
      if (rc_valid_in) begin
        if (first_in < 0) first_in = c;
        last_in = c;
        check_eq({tag, "_ray"}, {rc_src, rc_dir}, {src, dir});
        check_eq({tag, "_shape"}, {rc_trans_inv, rc_rot}, {mem[n_in].trans_inv, mem[n_in].rot});
        n_in++;
      end
      if (rc_valid_out) last_out = c;
      @(negedge clk);
    end
    check_eq({tag, "_done_seen"}, res_k > 0, 1);
    check_eq({tag, "_issued"}, n_in, exp_in);
    if (n > 0) begin
      check_eq({tag, "_first_issue"}, first_in, 2);
      check_eq({tag, "_no_bubble"}, last_in - first_in + 1, n_in);
      check_eq({tag, "_res_lat"}, res_k, last_out + 1);
    end else begin
      check_eq({tag, "_zero_lat"}, res_k >= 1 && res_k <= 2, 1);
    end
    got = res_now();
    check_eq({tag, "_payload"}, got, exp_q.pop_front());

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq({tag, "_hold_valid"}, bus.res_valid, 1);
      check_eq({tag, "_hold_payload"}, res_now(), got);
      check_eq({tag, "_hold_ready"}, bus.ray_ready, 0);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check_eq({tag, "_res_drop"}, bus.res_valid, 0);
    check_eq({tag, "_idle_ready"}, bus.ray_ready, 1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int k;
    bus.ray_valid = 1'b0; bus.res_ready = 1'b0; bus.num_shapes = '0;
    bus.ray_src = '0; bus.ray_dir = '0;
`ifdef RAYCAST_SCHED_ANY_HIT_EN
    bus.ray_any_hit = 1'b0;
`endif
    for (int i = 0; i < MAX_SHAPES; i++) set_shape(i, 1'b0, 16'h0);
    fill_mem();

    repeat (3) @(negedge clk);
    check_eq("reset_ray_ready", bus.ray_ready, 0);
    check_eq("reset_res_valid", bus.res_valid, 0);
    check_eq("reset_rc_valid_in", rc_valid_in, 0);
    check_eq("reset_shape_addr", shape_addr, 0);
    check_eq("reset_payload", res_now(), 0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("reset_release_ready", bus.ray_ready, 1);

    // Nearest hit: hit 4400, miss, hit 4000.
    set_shape(0, 1, 16'h4400); set_shape(1, 0, 16'h3C00); set_shape(2, 1, 16'h4000);
    run_ray(3, 0, 0, "nearest");
    run_ray(0, 0, 0, "zero");
    // Tie keeps the lower index; NaN hit ignored.
    set_shape(0, 1, 16'h3C00); set_shape(1, 1, 16'h3C00); set_shape(2, 1, 16'h7E00);
    run_ray(3, 0, 0, "tie");
    // Only a NaN hit: no result hit.
    set_shape(0, 0, 16'h3800); set_shape(1, 1, 16'h7C01);
    run_ray(2, 0, 0, "nan_only");
    // Sign bit ignored: BC00 ranks as 3C00 and beats 3E00.
    set_shape(0, 1, 16'hBC00); set_shape(1, 1, 16'h3E00);
    run_ray(2, 0, 0, "sign_bit");
    // Back-pressure then back-to-back ray.
    random_tables(5);
    run_ray(5, 0, 10, "backpressure");
    random_tables(4);
    run_ray(4, 0, 0, "back_to_back");
    // Full memory.
    random_tables(MAX_SHAPES);
    run_ray(MAX_SHAPES, 0, 1, "full");

    // Reset mid-ray at shape 5 of 8.
    random_tables(8);
    @(negedge clk);
    bus.num_shapes = CNT_W'(8); bus.ray_valid = 1'b1;
    k = 0;
    while (!bus.ray_ready && k < 20) begin @(negedge clk); k++; end
    @(negedge clk);
    bus.ray_valid = 1'b0;
    k = 0;
    while (shape_addr != 5 && k < 50) begin @(negedge clk); k++; end
    check_eq("rst_reach_shape5", shape_addr, 5);
    rst = 1'b0;
    #1;
    check_eq("rst_ray_ready", bus.ray_ready, 0);
    check_eq("rst_res_valid", bus.res_valid, 0);
    check_eq("rst_rc_valid_in", rc_valid_in, 0);
    check_eq("rst_shape_addr", shape_addr, 0);
    check_eq("rst_rc_src", rc_src, 0);
    check_eq("rst_payload", res_now(), 0);
    check_eq("rst_state", dbg_state, S_IDLE);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < LAT + 2; c++) begin
      @(negedge clk);
      check_eq("rst_stale_ignored", bus.res_valid, 0);
    end
    check_eq("rst_idle_ready", bus.ray_ready, 1);
    random_tables(6);
    run_ray(6, 0, 0, "post_reset");

`ifdef RAYCAST_SCHED_ANY_HIT_EN
    // Any-hit: first hit at shape 1, a closer hit at shape 3 is not taken.
    for (int i = 0; i < 8; i++) set_shape(i, 0, 16'h3000);
    set_shape(1, 1, 16'h4400); set_shape(3, 1, 16'h3C00);
    run_ray(8, 1, 0, "any_hit");
`endif

    for (int r = 0; r < 25; r++) begin
      int n;
      bit any;
      n = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12);
      any = 1'b0;
`ifdef RAYCAST_SCHED_ANY_HIT_EN
      any = 1'($urandom_range(0, 1));
`endif
      random_tables(n);
      run_ray(n, any, $urandom_range(0, 3), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
